regfile_writeback: RTL and testbench
====================================

// Module: regfile_writeback
// PURPOSE
//  Writeback sequencer in front of the CPU register file's single write port.
//  Merges single-cycle ALU results with variable-latency load returns, and buffers
//  loads in a small in-order queue. Drives dst_addr/dst_data/write_enable of the
//  register file from registered outputs. Keeps a pending-load scoreboard that
//  decode uses to stall on RAW/WAW hazards.
// PARAMETERS
//  XLEN      32  data width of results and register file
//  REG_AW    5   register address width (2**REG_AW registers, x0 hardwired zero)
//  LQ_DEPTH  2   load-result queue depth; power of 2, >=2
// PORTS
//  clk          in   1        clock, all state on rising edge
//  rst_n        in   1        asynchronous active-low reset
//  alu_valid    in   1        ALU result valid this cycle (no backpressure)
//  alu_rd       in   REG_AW   ALU destination register
//  alu_data     in   XLEN     ALU result
//  ld_issue     in   1        load issued to memory this cycle
//  ld_issue_rd  in   REG_AW   destination of the issued load
//  ld_valid     in   1        load data returning
//  ld_rd        in   REG_AW   destination of the returning load
//  ld_data      in   XLEN     returned load data
//  ld_ready     out  1        queue can accept a return; beat moves when ld_valid&&ld_ready
//  wb_we        out  1        register file write_enable
//  wb_addr      out  REG_AW   register file dst_addr
//  wb_data      out  XLEN     register file dst_data
//  busy_mask    out  2**REG_AW  bit r=1: load to xr outstanding or queued
//  stall_cnt    out  32       only with WB_STALL_CNT_EN, see CONFIGURATION
// BEHAVIOUR
//  Reset (async, any time): wb_we=0, wb_addr=0, wb_data=0, busy_mask=0, queue emptied,
//   stall_cnt=0. Any in-flight loads are dropped; no write is issued for them later.
//  ld_ready = !queue_full (combinational from state only); 1 during and after reset.
//  Select each cycle: ALU when alu_valid && alu_rd!=0 (ALU has priority);
//   else queue head if queue non-empty (head popped); else none.
//  wb_* registered at the edge after selection: ALU latency 1. A load accepted at edge E
//   is written at edge E+1 at the earliest (wb_we high during cycle E+1..E+2).
//  No selection -> wb_we=0; wb_addr/wb_data keep their previous values.
//  alu_rd==0: no write, and the queue may drain in that cycle.
//  Load beat with ld_rd==0: accepted and popped in order, but wb_we stays 0 for it.
//  Queue strictly FIFO. Pointers wrap modulo LQ_DEPTH. Full/empty are tracked with an
//   extra pointer bit. Push and pop in the same cycle are legal when full (net count
//   unchanged), but ld_ready still reads 0 that cycle.
//  Scoreboard: ld_issue with ld_issue_rd!=0 sets the bit at the next edge. Popping a
//   load entry with rd!=0 clears its bit at the same edge that asserts wb_we.
//   Set and clear of the same bit in one cycle: set wins.
//  Decode must not issue a second load or an ALU op to a busy register. An ALU write to
//   a busy register is a protocol error: simulation assertion fires, busy_mask unchanged.
//  No combinational path from any input to wb_*, busy_mask or ld_ready.
// CONFIGURATION
//  WB_STALL_CNT_EN defined: port stall_cnt present. It increments (wrapping at 2**32)
//   every cycle the ALU wins while the queue is non-empty.
//  Not defined: port and counter absent, no other behavioural change.
// STRUCTURE
//  Package wb_pkg: XLEN, REG_AW, NUM_REGS=2**REG_AW, typedef wb_src_t {WB_NONE, WB_ALU,
//   WB_LOAD}, typedef ld_entry_t {rd, data}.
//  Sub-module wb_load_fifo (parameterised depth FIFO of ld_entry_t). Top holds the
//   arbiter, the output registers and the scoreboard.
// TESTING
//  1 Reset mid-run, 2 beats queued, busy_mask=0x88 -> wb_we=0, busy_mask=0, ld_ready=1;
//    queued beats never written.
//  2 alu_valid, rd=5, data=0xDEADBEEF at edge N -> wb_we=1, addr=5, data=0xDEADBEEF in
//    cycle N+1 only.
//  3 ld_issue rd=7 -> busy_mask[7]=1. Then ld_valid rd=7 data=0x1234 at edge E ->
//    wb_we, addr=7 at edge E+1; busy_mask[7]=0 at that same edge.
//  4 alu_valid held 4 cycles while 3 loads (rd 1,2,3) return, LQ_DEPTH=2 -> ld_ready=0
//    after 2 beats. After the ALU idles, writes go x1,x2,x3 in order. With the macro,
//    stall_cnt counts every cycle the ALU wins while the queue is non-empty.
//  5 ld_issue rd=3 in the same cycle as the pop writing x3 -> busy_mask[3] stays 1.
//  6 alu rd=0, ld_issue rd=0, load return rd=0 -> no wb_we, busy_mask unchanged,
//    queue drains.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and widths for the register-file writeback sequencer.
package wb_pkg;
    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 2 ** REG_AW;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_LOAD = 2'd2
    } wb_src_t;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } ld_entry_t;
endpackage

// File: rtl/wb_load_fifo.sv
// In-order load-return queue; full/empty distinguished by an extra pointer bit.
module wb_load_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  ld_entry_t push_entry,
    input  logic      pop,
    output ld_entry_t head,
    output logic      empty,
    output logic      full
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    ld_entry_t   mem_q [DEPTH];
    ld_entry_t   mem_d [DEPTH];
    logic        do_push_s;
    logic        do_pop_s;

    // Occupancy flags and head entry from pointer state.
    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        head  = mem_q[rd_ptr_q[AW-1:0]];
    end

    // Next-state for storage and pointers; a push into a full queue needs a same-cycle pop.
    always_comb begin
        do_push_s = push && (!full || pop);
        do_pop_s  = pop && !empty;
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (do_push_s) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_entry;
            wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Queue state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {(AW+1){1'b0}};
            rd_ptr_q <= {(AW+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '{rd: {REG_AW{1'b0}}, data: {XLEN{1'b0}}};
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end
endmodule

// File: rtl/wb_protocol_chk.sv
// Protocol checker: decode must never send an ALU result to a register awaiting a load.
module wb_protocol_chk
    import wb_pkg::*;
(
    input logic                clk,
    input logic                rst_n,
    input logic                alu_valid,
    input logic [REG_AW-1:0]   alu_rd,
    input logic [NUM_REGS-1:0] busy_mask
);
    // Flags an ALU write that would race an outstanding load to the same register.
    a_alu_to_busy: assert property (@(posedge clk) disable iff (!rst_n)
        (alu_valid && (alu_rd != {REG_AW{1'b0}})) |-> !busy_mask[alu_rd])
        else $error("protocol: ALU write to busy register x%0d", alu_rd);
endmodule

// File: rtl/regfile_writeback.sv
// Writeback arbiter, output registers and pending-load scoreboard.
// Optional stall_cnt port and counter enabled by defining WB_STALL_CNT_EN.
module regfile_writeback
    import wb_pkg::*;
#(
    parameter int LQ_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                alu_valid,
    input  logic [REG_AW-1:0]   alu_rd,
    input  logic [XLEN-1:0]     alu_data,
    input  logic                ld_issue,
    input  logic [REG_AW-1:0]   ld_issue_rd,
    input  logic                ld_valid,
    input  logic [REG_AW-1:0]   ld_rd,
    input  logic [XLEN-1:0]     ld_data,
    output logic                ld_ready,
    output logic                wb_we,
    output logic [REG_AW-1:0]   wb_addr,
    output logic [XLEN-1:0]     wb_data,
    output logic [NUM_REGS-1:0] busy_mask
`ifdef WB_STALL_CNT_EN
    ,
    output logic [31:0]         stall_cnt
`endif
);
    logic                wb_we_q, wb_we_d;
    logic [REG_AW-1:0]   wb_addr_q, wb_addr_d;
    logic [XLEN-1:0]     wb_data_q, wb_data_d;
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [NUM_REGS-1:0] set_mask_s, clr_mask_s;
    wb_src_t             src_s;
    ld_entry_t           lq_head_s;
    logic                lq_empty_s, lq_full_s, lq_push_s, lq_pop_s;

    wb_load_fifo #(.DEPTH(LQ_DEPTH)) u_lq (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (lq_push_s),
        .push_entry ('{rd: ld_rd, data: ld_data}),
        .pop        (lq_pop_s),
        .head       (lq_head_s),
        .empty      (lq_empty_s),
        .full       (lq_full_s)
    );

    wb_protocol_chk u_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .busy_mask (busy_q)
    );

    // Source selection: a real ALU write beats the queue head; x0 ALU ops let the queue drain.
    always_comb begin
        src_s = WB_NONE;
        if (alu_valid && (alu_rd != {REG_AW{1'b0}})) begin
            src_s = WB_ALU;
        end else if (!lq_empty_s) begin
            src_s = WB_LOAD;
        end else begin
            src_s = WB_NONE;
        end
        lq_pop_s  = (src_s == WB_LOAD);
        lq_push_s = ld_valid && !lq_full_s;
    end

    // Next writeback port values and scoreboard update; issue set beats pop clear.
    always_comb begin
        wb_we_d    = 1'b0;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        clr_mask_s = {NUM_REGS{1'b0}};
        case (src_s)
            WB_ALU: begin
                wb_we_d   = 1'b1;
                wb_addr_d = alu_rd;
                wb_data_d = alu_data;
            end
            WB_LOAD: begin
                if (lq_head_s.rd != {REG_AW{1'b0}}) begin
                    wb_we_d    = 1'b1;
                    wb_addr_d  = lq_head_s.rd;
                    wb_data_d  = lq_head_s.data;
                    clr_mask_s = NUM_REGS'(1) << lq_head_s.rd;
                end else begin
                    wb_we_d = 1'b0;
                end
            end
            WB_NONE: wb_we_d = 1'b0;
            default: wb_we_d = 1'b0;
        endcase
        set_mask_s = (ld_issue && (ld_issue_rd != {REG_AW{1'b0}})) ?
                     (NUM_REGS'(1) << ld_issue_rd) : {NUM_REGS{1'b0}};
        busy_d     = (busy_q & ~clr_mask_s) | set_mask_s;
    end

    // Output and scoreboard registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_we_q   <= 1'b0;
            wb_addr_q <= {REG_AW{1'b0}};
            wb_data_q <= {XLEN{1'b0}};
            busy_q    <= {NUM_REGS{1'b0}};
        end else begin
            wb_we_q   <= wb_we_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            busy_q    <= busy_d;
        end
    end

    assign ld_ready  = !lq_full_s;
    assign wb_we     = wb_we_q;
    assign wb_addr   = wb_addr_q;
    assign wb_data   = wb_data_q;
    assign busy_mask = busy_q;

`ifdef WB_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Count cycles where an ALU write holds off a waiting load.
    always_comb begin
        stall_cnt_d = ((src_s == WB_ALU) && !lq_empty_s) ? (stall_cnt_q + 32'd1) : stall_cnt_q;
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_regfile_writeback.sv
// Directed self-checking bench for regfile_writeback (LQ_DEPTH=2).
module tb_regfile_writeback;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_issue;
    logic [4:0]  ld_issue_rd;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] busy_mask;
`ifdef WB_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    regfile_writeback #(.LQ_DEPTH(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .ld_issue    (ld_issue),
        .ld_issue_rd (ld_issue_rd),
        .ld_valid    (ld_valid),
        .ld_rd       (ld_rd),
        .ld_data     (ld_data),
        .ld_ready    (ld_ready),
        .wb_we       (wb_we),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .busy_mask   (busy_mask)
`ifdef WB_STALL_CNT_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
        ld_issue = 1'b0; ld_issue_rd = 5'd0;
        ld_valid = 1'b0; ld_rd = 5'd0; ld_data = 32'd0;
    endtask

    task automatic check_wb(input string tag, input logic we, input logic [4:0] addr,
                            input logic [31:0] data);
        check({tag, "_we"}, 32'(wb_we), 32'(we));
        check({tag, "_addr"}, 32'(wb_addr), 32'(addr));
        check({tag, "_data"}, wb_data, data);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        #3;
        check_wb("rst", 1'b0, 5'd0, 32'd0);
        check("rst_busy", busy_mask, 32'd0);
        check("rst_ready", 32'(ld_ready), 32'd1);
        #9 rst_n = 1'b1;
        tick();

        // ALU write, latency one, single cycle
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        tick();
        check_wb("alu", 1'b1, 5'd5, 32'hDEADBEEF);
        idle();
        tick();
        check_wb("alu_hold", 1'b0, 5'd5, 32'hDEADBEEF);

        // Single load: scoreboard set, then writeback one edge after acceptance
        ld_issue = 1'b1; ld_issue_rd = 5'd7;
        tick();
        idle();
        check("ld_busy_set", busy_mask, 32'h0000_0080);
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h1234;
        tick();
        idle();
        check("ld_accept_we", 32'(wb_we), 32'd0);
        check("ld_accept_busy", busy_mask, 32'h0000_0080);
        tick();
        check_wb("ld_wb", 1'b1, 5'd7, 32'h1234);
        check("ld_busy_clr", busy_mask, 32'd0);
        tick();
        check("ld_after_we", 32'(wb_we), 32'd0);

        // ALU busy four cycles while loads x1..x3 return
        ld_issue = 1'b1; ld_issue_rd = 5'd1; tick();
        ld_issue_rd = 5'd2; tick();
        ld_issue_rd = 5'd3; tick();
        idle();
        check("q_busy", busy_mask, 32'h0000_000E);
        alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hA0;
        ld_valid = 1'b1; ld_rd = 5'd1; ld_data = 32'h11;
        tick();
        check_wb("q_alu1", 1'b1, 5'd10, 32'hA0);
        check("q_ready1", 32'(ld_ready), 32'd1);
        alu_data = 32'hA1; ld_rd = 5'd2; ld_data = 32'h22;
        tick();
        check_wb("q_alu2", 1'b1, 5'd10, 32'hA1);
        check("q_ready2", 32'(ld_ready), 32'd0);
        alu_data = 32'hA2; ld_rd = 5'd3; ld_data = 32'h33;
        tick();
        check_wb("q_alu3", 1'b1, 5'd10, 32'hA2);
        check("q_ready3", 32'(ld_ready), 32'd0);
        alu_data = 32'hA3;
        tick();
        check_wb("q_alu4", 1'b1, 5'd10, 32'hA3);
        check("q_busy4", busy_mask, 32'h0000_000E);
`ifdef WB_STALL_CNT_EN
        check("q_stall", stall_cnt, 32'd3);
`endif
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
        tick();
        check_wb("q_x1", 1'b1, 5'd1, 32'h11);
        check("q_x1_busy", busy_mask, 32'h0000_000C);
        check("q_x1_ready", 32'(ld_ready), 32'd1);
        tick();
        ld_valid = 1'b0;
        check_wb("q_x2", 1'b1, 5'd2, 32'h22);
        check("q_x2_busy", busy_mask, 32'h0000_0008);
        // reissue to x3 in the same cycle its pending entry is popped
        ld_issue = 1'b1; ld_issue_rd = 5'd3;
        tick();
        idle();
        check_wb("q_x3", 1'b1, 5'd3, 32'h33);
        check("setwins_busy", busy_mask, 32'h0000_0008);
        tick();
        check("q_empty_we", 32'(wb_we), 32'd0);
`ifdef WB_STALL_CNT_EN
        check("q_stall_final", stall_cnt, 32'd3);
`endif
        ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h3333;
        tick();
        idle();
        tick();
        check_wb("x3_again", 1'b1, 5'd3, 32'h3333);
        check("x3_again_busy", busy_mask, 32'd0);

        // x0 traffic: nothing written, scoreboard untouched, queue drains
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFF;
        ld_issue = 1'b1; ld_issue_rd = 5'd0;
        ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h55;
        tick();
        check_wb("x0_a", 1'b0, 5'd3, 32'h3333);
        check("x0_a_busy", busy_mask, 32'd0);
        idle();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hEE;
        tick();
        check_wb("x0_b", 1'b0, 5'd3, 32'h3333);
        check("x0_b_ready", 32'(ld_ready), 32'd1);
        idle();
        ld_issue = 1'b1; ld_issue_rd = 5'd4;
        tick();
        idle();
        ld_valid = 1'b1; ld_rd = 5'd4; ld_data = 32'h44;
        tick();
        idle();
        tick();
        check_wb("x0_drained", 1'b1, 5'd4, 32'h44);

        // Reset mid-run with two loads queued
        ld_issue = 1'b1; ld_issue_rd = 5'd3; tick();
        ld_issue_rd = 5'd7; tick();
        idle();
        check("mr_busy", busy_mask, 32'h0000_0088);
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
        ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h3A;
        tick();
        ld_rd = 5'd7; ld_data = 32'h7A;
        tick();
        check("mr_full", 32'(ld_ready), 32'd0);
        #2 rst_n = 1'b0;
        idle();
        #1;
        check_wb("mr_rst", 1'b0, 5'd0, 32'd0);
        check("mr_rst_busy", busy_mask, 32'd0);
        check("mr_rst_ready", 32'(ld_ready), 32'd1);
`ifdef WB_STALL_CNT_EN
        check("mr_rst_stall", stall_cnt, 32'd0);
`endif
        tick();
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mr_no_wb", 32'(wb_we), 32'd0);
        end
        check("mr_busy_after", busy_mask, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
